// File: rtl/disparity_argmin_if.sv
// disparity_argmin_if: cost stream in, per-pixel disparity result out
//   restart_in      abort current search (sync)
//   cost_in         SSD cost, COST_WIDTH bits
//   cost_valid_in   cost_in valid this cycle
//   valid_out       one-cycle result strobe
//   disparity_out   argmin index
//   min_cost_out    best cost
//   second_cost_out runner-up cost
//   confident_out   best leads runner-up by more than MARGIN
interface disparity_argmin_if #(
    parameter int MAX_DISP   = 64,
    parameter int COST_WIDTH = 20
);
    localparam int DW = (MAX_DISP > 1) ? $clog2(MAX_DISP) : 1;
    logic                  restart_in;
    logic [COST_WIDTH-1:0] cost_in;
    logic                  cost_valid_in;
    logic                  valid_out;
    logic [DW-1:0]         disparity_out;
    logic [COST_WIDTH-1:0] min_cost_out;
    logic [COST_WIDTH-1:0] second_cost_out;
    logic                  confident_out;
    modport master (
        output restart_in, cost_in, cost_valid_in,
        input  valid_out, disparity_out, min_cost_out, second_cost_out, confident_out
    );
    modport slave (
        input  restart_in, cost_in, cost_valid_in,
        output valid_out, disparity_out, min_cost_out, second_cost_out, confident_out
    );
endinterface

// File: rtl/disparity_argmin.sv
// disparity_argmin: streaming argmin over MAX_DISP costs per pixel with runner-up and confidence
//   clk_in  clock (rising edge)
//   rst_in  asynchronous active-high reset
//   bus     disparity_argmin_if.slave (cost stream in, registered result out)
module disparity_argmin #(
    parameter int MAX_DISP   = 64,
    parameter int COST_WIDTH = 20,
    parameter int MARGIN     = 1000
) (
    input logic               clk_in,
    input logic               rst_in,
    disparity_argmin_if.slave bus
);
    localparam int DW = (MAX_DISP > 1) ? $clog2(MAX_DISP) : 1;
    localparam logic [COST_WIDTH-1:0] ONES = '1;
    typedef enum logic {IDLE, SEARCH} state_t;
    state_t                state, state_next;
    logic [DW-1:0]         idx, idx_next, best_idx, best_idx_next, cur_idx;
    logic [COST_WIDTH-1:0] best, best_next, second, second_next, cur_best, cur_second;
    logic                  fresh, last, confident;
    logic [COST_WIDTH:0]   gap;
    // A fresh search (IDLE or restart) sees initial running values, so index 0
    // of the next pixel can arrive in the same cycle the previous result strobes.
    always_comb begin
        fresh         = state == IDLE || bus.restart_in;
        cur_idx       = fresh ? '0 : idx;
        cur_best      = fresh ? ONES : best;
        cur_second    = fresh ? ONES : second;
        last          = bus.cost_valid_in && cur_idx == DW'(MAX_DISP - 1);
        best_next     = cur_best;
        best_idx_next = fresh ? '0 : best_idx;
        second_next   = cur_second;
        idx_next      = cur_idx;
        state_next    = fresh ? IDLE : state;
        if (bus.cost_valid_in) begin
            idx_next   = last ? '0 : cur_idx + 1'b1;
            state_next = last ? IDLE : SEARCH;
            if (bus.cost_in < cur_best) begin
                best_next     = bus.cost_in;
                best_idx_next = cur_idx;
                second_next   = cur_best;
            end else if (bus.cost_in < cur_second) begin
                second_next = bus.cost_in;
            end
        end
        gap       = {1'b0, second_next} - {1'b0, best_next};
        confident = (MAX_DISP == 1) || gap > (COST_WIDTH + 1)'(MARGIN);
    end
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state    <= IDLE;
            idx      <= '0;
            best     <= ONES;
            best_idx <= '0;
            second   <= ONES;
        end else begin
            state    <= state_next;
            idx      <= idx_next;
            best     <= best_next;
            best_idx <= best_idx_next;
            second   <= second_next;
        end
    end
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            bus.valid_out       <= 1'b0;
            bus.disparity_out   <= '0;
            bus.min_cost_out    <= '0;
            bus.second_cost_out <= '0;
            bus.confident_out   <= 1'b0;
        end else begin
            bus.valid_out <= last;
            if (last) begin
                bus.disparity_out   <= best_idx_next;
                bus.min_cost_out    <= best_next;
                bus.second_cost_out <= second_next;
                bus.confident_out   <= confident;
            end
        end
    end
endmodule

// File: doc/disparity_argmin.md
DISPARITY_ARGMIN -- requirements
Module: disparity_argmin

Interface
REQ-001 SHALL have parameter MAX_DISP, default 64, giving the number of candidate disparities per pixel; legal range 1..256.
REQ-002 SHALL have parameter COST_WIDTH, default 20, giving the cost width; 20 bits covers 6*255*255 = 390150.
REQ-003 SHALL have parameter MARGIN, default 1000, giving the minimum lead of the best cost over the runner-up for a confident match.
REQ-004 SHALL have port clk_in, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_in, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port restart_in, input, 1 bit: synchronous abort of the current search.
REQ-007 SHALL have port cost_in, input, COST_WIDTH bits: sum-of-squared-differences cost from the upstream MAC engine.
REQ-008 SHALL have port cost_valid_in, input, 1 bit: cost_in is valid this cycle.
REQ-009 SHALL have port valid_out, output, 1 bit: one-cycle result strobe.
REQ-010 SHALL have port disparity_out, output, max(1,$clog2(MAX_DISP)) bits: index of the minimum cost.
REQ-011 SHALL have port min_cost_out, output, COST_WIDTH bits: the minimum cost.
REQ-012 SHALL have port second_cost_out, output, COST_WIDTH bits: the runner-up cost.
REQ-013 SHALL have port confident_out, output, 1 bit: the match is unambiguous.

Function
REQ-014 SHALL treat costs accepted on cost_valid_in cycles as disparities 0,1,...,MAX_DISP-1 in arrival order; cycles without cost_valid_in are ignored and may appear anywhere.
REQ-015 SHALL implement FSM states IDLE (index 0, no partial search) and SEARCH (1..MAX_DISP-1 costs accepted).
REQ-016 SHALL transition IDLE->SEARCH on an accepted cost when MAX_DISP>1.
REQ-017 SHALL transition SEARCH->IDLE on acceptance of the MAX_DISP-th cost, or on restart_in.
REQ-018 SHALL track the running best cost and index and the running second-best cost.
- Update uses strict less-than, so on ties the lowest index wins.
- A cost equal to the best becomes the second-best.
- Second-best initialises to all-ones.
REQ-019 SHALL assert valid_out for exactly one cycle, the cycle after the MAX_DISP-th cost is accepted.
- Outputs are registered.
- disparity_out, min_cost_out, second_cost_out and confident_out hold their values until the next result or reset.
REQ-020 SHALL set confident_out = 1 iff (second_cost - min_cost) > MARGIN.
- The subtraction is unsigned and COST_WIDTH+1 bits wide, so it cannot overflow.
- With MAX_DISP=1, second_cost_out is all-ones and confident_out = 1.
REQ-021 SHALL accept back-to-back pixels with no bubble: index 0 of the next pixel may arrive in the same cycle valid_out is high and is processed correctly.
REQ-022 SHALL, on restart_in, discard any partial search with no valid_out; if cost_valid_in is high in the same cycle, that cost is index 0 of a fresh search.
REQ-023 SHALL have no ready/backpressure; it accepts one cost every cycle.

Reset
REQ-024 SHALL, on rst_in asserted at any time including mid-search, immediately clear the following without waiting for a clock edge:
- state to IDLE and index to 0;
- running best, best index and second-best to their initial values;
- valid_out, disparity_out, min_cost_out, second_cost_out and confident_out to 0.
REQ-025 SHALL accept a cost on the first rising edge after rst_in deasserts as index 0.

Verification (MAX_DISP=4, MARGIN=100)
REQ-026 Basic: costs 500,300,700,900 on consecutive cycles -> valid_out one cycle after 900; disparity 1, min 300, second 500, confident 1.
REQ-027 Tie: costs 200,200,400,400 -> disparity 0, min 200, second 200, confident 0.
REQ-028 Back-to-back: 500,300,700,900 then immediately 60000,60000,0,390150 -> two strobes four cycles apart; second result is disparity 2, min 0, second 60000, confident 1.
REQ-029 Gapped: the REQ-026 costs with 0-3 idle cycles between them -> identical result, strobe one cycle after the 4th cost.
REQ-030 Restart: 10,20, then restart_in with cost 800 in the same cycle, then 50,900,700 -> single strobe: disparity 1, min 50, second 700, confident 1.
REQ-031 Async reset: rst_in pulsed between clock edges after two costs -> outputs 0 before the next edge, no strobe; the next four costs 9,8,7,6 -> disparity 3, min 6, second 7, confident 0.
